// File: rtl/risc_pkg.sv
// Shared ISA constants for the 16-bit multicycle RISC core:
// opcodes, instruction field positions and the LM/SM sequencer states.
package risc_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADI = 4'd1;
  localparam logic [3:0] OP_NDU = 4'd2;
  localparam logic [3:0] OP_LHI = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SW  = 4'd5;
  localparam logic [3:0] OP_LM  = 4'd6;
  localparam logic [3:0] OP_SM  = 4'd7;
  localparam logic [3:0] OP_JAL = 4'd8;
  localparam logic [3:0] OP_JLR = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd12;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 9;
  localparam int RB_HI  = 8;
  localparam int RB_LO  = 6;
  localparam int RC_HI  = 5;
  localparam int RC_LO  = 3;
  localparam int CZ_HI  = 1;
  localparam int CZ_LO  = 0;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_SCAN = 2'd1,
    LS_DONE = 2'd2
  } lmsm_state_t;

  function automatic logic op_illegal(
    input logic [3:0] op
  );
    logic ill;
    ill = 1'b0;
    case (op)
      4'd10, 4'd11, 4'd13,
      4'd14, 4'd15: ill = 1'b1;
      default:      ill = 1'b0;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/ir_decode_lmsm_if.sv
// LM/SM register-list handshake between the controller
// (master) and the decode stage sequencer (slave).
interface ir_decode_lmsm_if;

  logic       lmsm_start;
  logic       lmsm_step;
  logic [2:0] lmsm_reg;
  logic       lmsm_valid;
  logic [3:0] lmsm_count;
  logic       lmsm_done;

  modport master (
    output lmsm_start,
    output lmsm_step,
    input  lmsm_reg,
    input  lmsm_valid,
    input  lmsm_count,
    input  lmsm_done
  );

  modport slave (
    input  lmsm_start,
    input  lmsm_step,
    output lmsm_reg,
    output lmsm_valid,
    output lmsm_count,
    output lmsm_done
  );

endinterface

// File: rtl/pri_enc8.sv
// Lowest-set-bit encoder: 8-bit vector in,
// index of the lowest set bit plus any-set flag out.
module pri_enc8 (
  input  logic [7:0] vec_i,
  output logic [2:0] idx_o,
  output logic       any_o
);

  always_comb begin
    idx_o = 3'd0;
    any_o = |vec_i;
    for (int i = 7; i >= 0; i--) begin
      if (vec_i[i]) idx_o = i[2:0];
    end
  end

endmodule

// File: rtl/ir_decode_lmsm.sv
// Instruction register, field/immediate decode and the
// LM/SM register-list sequencer of the multicycle core.
module ir_decode_lmsm
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              proc_rst,
  input  logic [15:0]       mem_data,
  input  logic              ir_load,
  output logic [15:0]       IR,
  output logic [3:0]        opcode,
  output logic [2:0]        ra,
  output logic [2:0]        rb,
  output logic [2:0]        rc,
  output logic [1:0]        cz,
  output logic [15:0]       se6,
  output logic [15:0]       se9,
  output logic [15:0]       lhi_val,
  output logic              illegal,
  ir_decode_lmsm_if.slave   lmsm
);

  logic [15:0] ir_q;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  count_q;
  logic [2:0]  reg_q;
  logic        valid_q;
  logic        done_q;
  lmsm_state_t state_q;
  logic [2:0]  enc_idx;
  logic        enc_any;
  logic        is_lmsm;
  logic        accept;
  logic        advance;

  always_ff @(posedge clk) begin
    if (proc_rst) begin
      ir_q <= 16'h0000;
    end else if (ir_load) begin
      ir_q <= mem_data;
    end
  end

  assign IR      = ir_q;
  assign opcode  = ir_q[OPC_HI:OPC_LO];
  assign ra      = ir_q[RA_HI:RA_LO];
  assign rb      = ir_q[RB_HI:RB_LO];
  assign rc      = ir_q[RC_HI:RC_LO];
  assign cz      = ir_q[CZ_HI:CZ_LO];
  assign se6     = {{10{ir_q[5]}}, ir_q[5:0]};
  assign se9     = {{7{ir_q[8]}}, ir_q[8:0]};
  assign lhi_val = {ir_q[8:0], 7'b0};
  assign illegal = op_illegal(opcode);

  assign is_lmsm = (opcode == OP_LM) ||
                   (opcode == OP_SM);
  assign accept  = (state_q == LS_IDLE) &&
                   lmsm.lmsm_start && is_lmsm;
  assign advance = (state_q == LS_SCAN) &&
                   lmsm.lmsm_step;

  // m & (m-1) drops the lowest set bit,
  // i.e. the register being handed out now
  always_comb begin
    mask_d = mask_q;
    unique case (1'b1)
      accept:  mask_d = ir_q[7:0];
      advance: mask_d = mask_q & (mask_q - 8'd1);
      default: mask_d = mask_q;
    endcase
  end

  pri_enc8 u_enc (
    .vec_i (mask_d),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_q <= LS_IDLE;
      mask_q  <= 8'h00;
      count_q <= 4'd0;
      reg_q   <= 3'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      reg_q  <= enc_idx;
      done_q <= 1'b0;
      case (state_q)
        LS_IDLE: begin
          if (accept) begin
            count_q <= 4'd0;
            valid_q <= enc_any;
            done_q  <= ~enc_any;
            state_q <= enc_any ? LS_SCAN : LS_DONE;
          end
        end
        LS_SCAN: begin
          if (advance) begin
            count_q <= count_q + 4'd1;
            if (!enc_any) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= LS_DONE;
            end
          end
        end
        LS_DONE: begin
          valid_q <= 1'b0;
          state_q <= LS_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= LS_IDLE;
        end
      endcase
    end
  end

  assign lmsm.lmsm_reg   = reg_q;
  assign lmsm.lmsm_valid = valid_q;
  assign lmsm.lmsm_count = count_q;
  assign lmsm.lmsm_done  = done_q;

endmodule

// File: tb/tb_ir_decode_lmsm.sv
// Scoreboard bench for ir_decode_lmsm: directed loads and
// LM/SM scans, with a negedge monitor checking each transfer.
module tb_ir_decode_lmsm;

  typedef struct {
    bit         dn;
    logic [2:0] r;
    logic [3:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        proc_rst;
  logic [15:0] mem_data;
  logic        ir_load;
  logic [15:0] IR;
  logic [3:0]  opcode;
  logic [2:0]  ra, rb, rc;
  logic [1:0]  cz;
  logic [15:0] se6, se9, lhi_val;
  logic        illegal;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  ir_decode_lmsm_if lif ();

  ir_decode_lmsm dut (
    .clk      (clk),
    .proc_rst (proc_rst),
    .mem_data (mem_data),
    .ir_load  (ir_load),
    .IR       (IR),
    .opcode   (opcode),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc),
    .cz       (cz),
    .se6      (se6),
    .se9      (se9),
    .lhi_val  (lhi_val),
    .illegal  (illegal),
    .lmsm     (lif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] w);
    ir_load  = 1'b1;
    mem_data = w;
    cyc();
    ir_load  = 1'b0;
  endtask

  task automatic push(input bit dn,
                      input logic [2:0] r,
                      input logic [3:0] c);
    exp_t e;
    e.dn = dn;
    e.r  = r;
    e.c  = c;
    q.push_back(e);
  endtask

  task automatic pulse_start();
    lif.lmsm_start = 1'b1;
    cyc();
    lif.lmsm_start = 1'b0;
  endtask

  // monitor: a transfer is valid&&step, completion is done
  always @(negedge clk) begin
    exp_t e;
    if (lif.lmsm_valid === 1'b1 &&
        lif.lmsm_done === 1'b1) begin
      chk("valid_with_done", 16'd1, 16'd0);
    end
    if (lif.lmsm_valid === 1'b1 &&
        lif.lmsm_step === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_xfer", {13'd0, lif.lmsm_reg}, 16'hFFFF);
      end else begin
        e = q.pop_front();
        chk("xfer_kind", 16'd0, {15'd0, e.dn});
        chk("xfer_reg", {13'd0, lif.lmsm_reg}, {13'd0, e.r});
        chk("xfer_count", {12'd0, lif.lmsm_count}, {12'd0, e.c});
      end
    end
    if (lif.lmsm_done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {12'd0, lif.lmsm_count}, 16'hFFFF);
      end else begin
        e = q.pop_front();
        chk("done_kind", 16'd1, {15'd0, e.dn});
        chk("done_count", {12'd0, lif.lmsm_count}, {12'd0, e.c});
      end
    end
  end

  initial begin
    proc_rst       = 1'b1;
    ir_load        = 1'b1;
    mem_data       = 16'hFFFF;
    lif.lmsm_start = 1'b0;
    lif.lmsm_step  = 1'b0;
    cyc(2);
    proc_rst = 1'b0;
    ir_load  = 1'b0;
    chk("rst_ir", IR, 16'h0000);
    chk("rst_illegal", {15'd0, illegal}, 16'd0);
    chk("rst_valid", {15'd0, lif.lmsm_valid}, 16'd0);
    chk("rst_count", {12'd0, lif.lmsm_count}, 16'd0);
    chk("rst_reg", {13'd0, lif.lmsm_reg}, 16'd0);

    load(16'h13FB);
    chk("adi_op", {12'd0, opcode}, 16'd1);
    chk("adi_ra", {13'd0, ra}, 16'd1);
    chk("adi_rb", {13'd0, rb}, 16'd7);
    chk("adi_rc", {13'd0, rc}, 16'd7);
    chk("adi_se6", se6, 16'hFFFB);
    chk("adi_se9", se9, 16'hFFFB);
    load(16'h3155);
    chk("lhi_val", lhi_val, 16'hAA80);
    chk("lhi_cz", {14'd0, cz}, 16'd1);
    chk("lhi_se6", se6, 16'h0015);

    // LM list A5 -> 0,2,5,7 back to back
    load(16'h62A5);
    push(0, 3'd0, 4'd0);
    push(0, 3'd2, 4'd1);
    push(0, 3'd5, 4'd2);
    push(0, 3'd7, 4'd3);
    push(1, 3'd0, 4'd4);
    pulse_start();
    lif.lmsm_step = 1'b1;
    cyc(4);
    lif.lmsm_step = 1'b0;
    chk("lm_done_now", {15'd0, lif.lmsm_done}, 16'd1);
    cyc(2);
    chk("lm_count_hold", {12'd0, lif.lmsm_count}, 16'd4);
    chk("lm_valid_off", {15'd0, lif.lmsm_valid}, 16'd0);

    // empty SM list
    load(16'h7E00);
    push(1, 3'd0, 4'd0);
    pulse_start();
    chk("sm_empty_done", {15'd0, lif.lmsm_done}, 16'd1);
    chk("sm_empty_valid", {15'd0, lif.lmsm_valid}, 16'd0);
    lif.lmsm_step = 1'b1;
    cyc();
    lif.lmsm_step = 1'b0;
    chk("sm_done_pulse", {15'd0, lif.lmsm_done}, 16'd0);
    cyc(2);

    // full LM list, step every other cycle, IR reload mid-scan
    load(16'h60FF);
    for (int i = 0; i < 8; i++) push(0, i[2:0], i[3:0]);
    push(1, 3'd0, 4'd8);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      lif.lmsm_step = (i % 2 == 1);
      ir_load       = (i == 5);
      mem_data      = 16'h0000;
      cyc();
    end
    lif.lmsm_step = 1'b0;
    ir_load       = 1'b0;
    chk("full_ir_new", IR, 16'h0000);
    cyc(3);
    chk("full_count", {12'd0, lif.lmsm_count}, 16'd8);

    // reset after three transfers
    load(16'h600F);
    push(0, 3'd0, 4'd0);
    push(0, 3'd1, 4'd1);
    push(0, 3'd2, 4'd2);
    pulse_start();
    lif.lmsm_step = 1'b1;
    cyc(3);
    lif.lmsm_step = 1'b0;
    proc_rst      = 1'b1;
    cyc();
    proc_rst = 1'b0;
    chk("mid_rst_valid", {15'd0, lif.lmsm_valid}, 16'd0);
    chk("mid_rst_count", {12'd0, lif.lmsm_count}, 16'd0);
    chk("mid_rst_done", {15'd0, lif.lmsm_done}, 16'd0);
    lif.lmsm_step = 1'b1;
    cyc(2);
    lif.lmsm_step = 1'b0;

    load(16'hA000);
    chk("ill_a", {15'd0, illegal}, 16'd1);
    chk("ill_a_op", {12'd0, opcode}, 16'd10);
    load(16'hC000);
    chk("beq_legal", {15'd0, illegal}, 16'd0);

    // start with a non-LM/SM opcode is ignored
    load(16'h00FF);
    pulse_start();
    lif.lmsm_step = 1'b1;
    cyc(3);
    lif.lmsm_step = 1'b0;
    chk("add_valid", {15'd0, lif.lmsm_valid}, 16'd0);
    chk("add_count", {12'd0, lif.lmsm_count}, 16'd0);
    cyc(2);

    chk("sb_empty", q.size(), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_decode_lmsm.md
# ir_decode_lmsm

Instruction register and decode stage for the multicycle 16-bit RISC core. It sits between memory read data and the controller/datapath. It latches the fetched instruction and presents the decoded fields and sign-extended immediates to the datapath muxes. It also runs the register-list sequencer for LM/SM: it walks IR[7:0] lowest-bit-first and hands one register index per step to the register file and address adder.

## Interface
Parameters:
- none. Widths are fixed by the ISA: 16-bit word, 8 registers.

Ports:
- clk  in  1  core clock; all state updates on posedge clk
- proc_rst  in  1  reset; synchronous, active-high
- mem_data  in  16  instruction word from memory read port
- ir_load  in  1  capture mem_data into IR this cycle
- lmsm_start  in  1  begin register-list scan of current IR (LM/SM only)
- lmsm_step  in  1  current register has been transferred; advance
- IR  out  16  instruction register
- opcode  out  4  IR[15:12]
- ra, rb, rc  out  3 each  IR[11:9], IR[8:6], IR[5:3]
- cz  out  2  IR[1:0] condition field
- se6  out  16  sign-extend of IR[5:0]
- se9  out  16  sign-extend of IR[8:0]
- lhi_val  out  16  {IR[8:0], 7'b0}
- illegal  out  1  opcode is one of 10, 11, 13, 14, 15
- lmsm_reg  out  3  index of the register to transfer now
- lmsm_valid  out  1  lmsm_reg is meaningful
- lmsm_count  out  4  registers already transferred (0..8); datapath uses it as the address offset from Ra
- lmsm_done  out  1  one-cycle pulse when the list is exhausted

## Operation
- Opcode map: 0 ADD, 1 ADI, 2 NDU, 3 LHI, 4 LW, 5 SW, 6 LM, 7 SM, 8 JAL, 9 JLR, 12 BEQ.
- IR updates only when ir_load=1; otherwise it holds.
- All field, immediate and illegal outputs are combinational from IR.
- Sequencer FSM states: IDLE, SCAN, DONE.
  - IDLE:
    - lmsm_start=1 and opcode is 6 or 7: mask <= IR[7:0], count <= 0.
    - If IR[7:0]==0 the next state is DONE; otherwise the next state is SCAN.
    - lmsm_start with any other opcode is ignored and the FSM stays in IDLE.
  - SCAN:
    - lmsm_valid=1 and lmsm_reg = index of the lowest set bit of mask.
    - On lmsm_step: clear that bit and increment count.
    - If the cleared bit was the last set bit, the next state is DONE; otherwise stay in SCAN.
  - DONE: lmsm_done=1 for exactly one cycle, lmsm_valid=0, then the FSM goes to IDLE.
- lmsm_step in IDLE or DONE is ignored.
- lmsm_start in SCAN or DONE is ignored.
- ir_load during SCAN changes IR but not mask, count, or the scan.
- Reset values:
  - IR=16'h0000, so opcode=0 and illegal=0.
  - FSM in IDLE, mask=0, count=0.
  - lmsm_valid=0, lmsm_done=0, lmsm_reg=0.
- Reset asserted mid-scan wins over every other input: the next cycle is IDLE with all outputs at their reset values.

## Timing
- ir_load at edge n: the new IR and all decode outputs are valid after edge n, in cycle n+1.
- ir_load and lmsm_start in the same cycle: the scan latches the old IR[7:0] (registered IR). The controller must assert lmsm_start at least one cycle after ir_load.
- lmsm_start at cycle n: lmsm_valid and the first lmsm_reg appear in cycle n+1.
- Step at cycle k on a non-final register: the next lmsm_reg and count+1 appear in cycle k+1.
- Step at cycle k on the final register: lmsm_done=1 and lmsm_valid=0 in cycle k+1, and count=popcount(IR[7:0]).
- Empty list: lmsm_start at cycle n gives lmsm_done=1 in cycle n+1, with count=0 and lmsm_valid never high.
- Throughput: one register per cycle when lmsm_step is held high.
- lmsm_count holds its final value through IDLE until the next accepted lmsm_start.

## Structure
- Shared package risc_pkg holds:
  - opcode localparams (OP_ADD..OP_BEQ);
  - field bit positions;
  - FSM state encoding for lmsm_state_t.
- The controller imports the same opcode constants.
- One sub-module, pri_enc8: combinational lowest-set-bit encoder, 8-bit in, 3-bit index plus any-set out.
- Target size: roughly 150–200 lines of RTL, split into IR register, decode assigns, FSM, mask/count registers, and the pri_enc8 instance.

## Test plan
- Reset with proc_rst=1 for 2 cycles while ir_load=1 and mem_data=16'hFFFF -> IR=0, illegal=0, lmsm_valid=0, lmsm_count=0.
- Load 16'h13FB (ADI, Ra=1, Rb=7, imm6=-5) -> opcode=1, ra=1, rb=7, se6=16'hFFFB; load 16'h3155 -> lhi_val=16'hAA80.
- Load LM 16'h62A5, pulse lmsm_start, then hold lmsm_step high -> lmsm_reg sequence 0, 2, 5, 7 on consecutive cycles, lmsm_done pulse in the following cycle, lmsm_count=4.
- Load SM 16'h7E00 (empty list), pulse lmsm_start -> lmsm_done the next cycle, lmsm_valid never 1, count=0.
- LM 16'h60FF with lmsm_step toggled every other cycle, plus ir_load=16'h0000 mid-scan -> all 8 indices 0..7 emitted in order, count=8, scan unaffected by the new IR.
- Assert proc_rst during SCAN after 3 steps -> next cycle IDLE, lmsm_valid=0, count=0; load 16'hA000 -> illegal=1; lmsm_start with the ADD opcode -> no response.
